pixel_sink_fb: RTL and testbench
================================

PIXEL_SINK_FB -- requirements
Module: pixel_sink_fb

Interface
REQ-001 Parameter WIDTH, default 160, framebuffer width in pixels.
REQ-002 Parameter HEIGHT, default 120, framebuffer height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, number of pixel-write entries buffered (power of 2).
REQ-004 clock  input  1  single clock, all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 plot  input  1  pixel-write request; accepted on a clock edge where plot && ready.
REQ-007 x  input  8  pixel column of the write request.
REQ-008 y  input  7  pixel row of the write request.
REQ-009 colour  input  1  pixel value of the write request.
REQ-010 ready  output  1  sink can accept a write this cycle.
REQ-011 clear  input  1  request to zero the entire framebuffer.
REQ-012 rd_en  input  1  readback request for (rd_x, rd_y).
REQ-013 rd_x  input  8  readback column.
REQ-014 rd_y  input  7  readback row.
REQ-015 rd_colour  output  1  readback pixel value, qualified by rd_valid.
REQ-016 rd_valid  output  1  one-cycle pulse marking rd_colour valid.
REQ-017 pixel_count  output  15  pixels committed to RAM since the last clear; saturates at 32767.

Function
REQ-018 Storage SHALL be a WIDTH*HEIGHT x 1 RAM, one access per cycle, address = y*WIDTH + x (15 bits).
REQ-019 State machine SHALL have two states: CLEAR and RUN.
REQ-020 CLEAR: internal sweep counter writes 0 to addresses 0..WIDTH*HEIGHT-1, one per cycle; ready=0; rd_en ignored (rd_valid=0); pixel_count held at 0.
REQ-021 CLEAR -> RUN on the cycle after address WIDTH*HEIGHT-1 is written (19200 cycles for defaults).
REQ-022 RUN -> CLEAR when clear=1; FIFO SHALL be flushed in the same edge and sweep SHALL restart at 0; clear during CLEAR restarts sweep at 0.
REQ-023 ready = (state==RUN) && !fifo_full && !clear.
REQ-024 Accepted {x,y,colour} SHALL be pushed into the FIFO in order; no entry is lost or duplicated.
REQ-025 RAM port priority in RUN: rd_en wins; otherwise the FIFO head is written and popped.
REQ-026 Drain SHALL commit at most one entry per cycle; an entry pushed at edge N is committable at edge N+1 at the earliest.
REQ-027 Simultaneous push and pop SHALL keep occupancy unchanged; push while full is impossible (ready=0).
REQ-028 Readback: rd_en at edge N -> rd_valid=1 and rd_colour = RAM contents at edge N+1; pending FIFO entries SHALL NOT be forwarded.
REQ-029 pixel_count SHALL increment by 1 per committed FIFO entry, saturating at 32767.
REQ-030 Back-to-back rd_en every cycle SHALL stall draining indefinitely; ready drops once the FIFO fills.

Reset
REQ-031 On reset: state=CLEAR, sweep counter=0, FIFO empty, ready=0, rd_valid=0, rd_colour=0, pixel_count=0.
REQ-032 Reset mid-sweep or mid-drain SHALL discard all pending entries and restart the full sweep.

Configuration
REQ-033 Macro FB_CLIP_EN defined: an entry with x>=WIDTH or y>=HEIGHT is accepted, popped without a RAM write and not counted; a readback with an out-of-range address returns rd_colour=0 with rd_valid=1.
REQ-034 FB_CLIP_EN undefined: out-of-range coordinates wrap once (x>=WIDTH -> x-WIDTH; y>=HEIGHT -> y-HEIGHT) before address calculation, for writes and reads, and are counted normally.

Verification
REQ-035 Reset, then idle -> ready=0 for exactly 19200 cycles, then ready=1; reads of (0,0) and (159,119) return 0.
REQ-036 Write a 5x5 block of 1s at start (10,20), one pixel per cycle -> pixel_count=25; read (14,24)=1, (15,24)=0.
REQ-037 Hold rd_en=1 for 10 cycles while plotting 6 pixels -> ready low after 4 accepted; all 6 committed after rd_en drops; pixel_count=6.
REQ-038 Plot (3,3)=1 then assert clear with 2 entries queued -> FIFO flushed, 19200-cycle sweep, pixel_count=0, read (3,3)=0.
REQ-039 Plot (165,5)=1: with FB_CLIP_EN -> pixel_count unchanged, read (5,5)=0; without -> read (5,5)=1, pixel_count+1.
REQ-040 Assert reset mid-drain with 3 entries queued -> none committed, sweep restarts at address 0, pixel_count=0.

Source files
------------

// File: rtl/pixel_sink_fb_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_sink_fb_if
//  Brief    : Pixel-write and readback channels of the pixel_sink_fb block.
//             The master drives write requests and readback requests; the
//             slave (the framebuffer) returns ready and the readback data.
//  Revision : 1.0 - initial release
// ============================================================================
interface pixel_sink_fb_if;
  // write channel
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic       colour;
  logic       ready;
  // readback channel
  logic       rd_en;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_colour;
  logic       rd_valid;

  modport master (
    output plot, x, y, colour, rd_en, rd_x, rd_y,
    input  ready, rd_colour, rd_valid
  );

  modport slave (
    input  plot, x, y, colour, rd_en, rd_x, rd_y,
    output ready, rd_colour, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/pixel_sink_fb.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_sink_fb
//  Brief    : 1-bit-per-pixel framebuffer sink. Accepted pixel writes are
//             queued in a small FIFO and drained into a WIDTH*HEIGHT x 1 RAM
//             whenever no readback claims the RAM port. A full-RAM clear
//             sweep runs after reset and on request.
//  Options  : FB_CLIP_EN - out-of-range coordinates are dropped on write and
//             read back as 0. Undefined: they wrap once into range.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_sink_fb #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        clear,
  output logic [14:0]      pixel_count,
  pixel_sink_fb_if.slave   bus
);

  localparam int          NPIX      = WIDTH * HEIGHT;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
  localparam logic [14:0] W15       = 15'(WIDTH);
  localparam logic [7:0]  W8        = 8'(WIDTH);
  localparam logic [6:0]  H7        = 7'(HEIGHT);
  localparam logic [14:0] CNT_MAX   = 15'h7FFF;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t      state_q;
  logic [14:0] sweep_q;
  logic [14:0] pixel_count_q;
  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;
  logic        rd_valid_q;
  logic        rd_colour_q;
  // FIFO entry layout: {x[7:0], y[6:0], colour}
  logic [15:0] fifo_q [FIFO_DEPTH];
  logic        mem_q  [NPIX];

  // Single wrap into range; wider overshoots are not expected from callers.
  function automatic logic [14:0] addr_of(input logic [7:0] px, input logic [6:0] py);
    logic [7:0] xw;
    logic [6:0] yw;
    xw = (px >= W8) ? (px - W8) : px;
    yw = (py >= H7) ? (py - H7) : py;
    return 15'(yw) * W15 + 15'(xw);
  endfunction

`ifdef FB_CLIP_EN
  function automatic logic in_range(input logic [7:0] px, input logic [6:0] py);
    return (px < W8) && (py < H7);
  endfunction
`endif

  logic        run, fifo_empty, fifo_full, push, pop, commit, rd_go;
  logic        head_ok, rd_ok;
  logic [15:0] head;
  logic        ram_we, ram_wdata;
  logic [14:0] ram_waddr, ram_raddr;

  assign run        = (state_q == S_RUN);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign bus.ready  = run && !fifo_full && !clear;
  assign push       = bus.plot && bus.ready;
  // Readback owns the RAM port; a clear edge flushes rather than drains.
  assign rd_go      = run && bus.rd_en;
  assign pop        = run && !clear && !bus.rd_en && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q[PW-1:0]];

`ifdef FB_CLIP_EN
  assign head_ok = in_range(head[15:8], head[7:1]);
  assign rd_ok   = in_range(bus.rd_x, bus.rd_y);
`else
  assign head_ok = 1'b1;
  assign rd_ok   = 1'b1;
`endif

  assign commit    = pop && head_ok;
  assign ram_we    = !reset && ((state_q == S_CLEAR) || commit);
  assign ram_waddr = run ? addr_of(head[15:8], head[7:1]) : sweep_q;
  assign ram_wdata = run ? head[0] : 1'b0;
  assign ram_raddr = addr_of(bus.rd_x, bus.rd_y);

  assign pixel_count  = pixel_count_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_colour = rd_colour_q;

  // Framebuffer RAM write port: sweep zeros in CLEAR, FIFO head in RUN.
  always_ff @(posedge clock) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
  end

  // FIFO storage; occupancy is tracked by the pointers in the control block.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= {bus.x, bus.y, bus.colour};
  end

  // Control FSM: sweep, FIFO pointers, readback and committed-pixel count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      sweep_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_valid_q    <= 1'b0;
      rd_colour_q   <= 1'b0;
      pixel_count_q <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) rd_colour_q <= rd_ok ? mem_q[ram_raddr] : 1'b0;
      case (state_q)
        S_CLEAR: begin
          pixel_count_q <= '0;
          if (clear) begin
            sweep_q <= '0;
          end else if (sweep_q == LAST_ADDR) begin
            sweep_q <= '0;
            state_q <= S_RUN;
          end else begin
            sweep_q <= sweep_q + 15'd1;
          end
        end
        S_RUN: begin
          if (clear) begin
            state_q       <= S_CLEAR;
            sweep_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pixel_count_q <= '0;
          end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (commit && (pixel_count_q != CNT_MAX))
              pixel_count_q <= pixel_count_q + 15'd1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_sink_fb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_sink_fb
//  Brief    : Directed bench for pixel_sink_fb. Readback expectations go into
//             a queue as each read is issued; a monitor pops and compares on
//             every rd_valid. Honours FB_CLIP_EN for the out-of-range case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sink_fb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [14:0] pixel_count;
  int          checks = 0;
  int          failures = 0;
  int          exp_q[$];

  pixel_sink_fb_if bus ();

  pixel_sink_fb dut (
    .clock       (clk),
    .reset       (rst),
    .clear       (clear),
    .pixel_count (pixel_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every readback pulse consumes one expectation.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=rd_valid expected=no_read");
      end else begin
        chk("readback", int'(bus.rd_colour), exp_q.pop_front());
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int x, input int y, input int e);
    bus.rd_en = 1'b1;
    bus.rd_x  = 8'(x);
    bus.rd_y  = 7'(y);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
  endtask

  // Leaves plot asserted so consecutive calls issue one write per cycle.
  task automatic plot_px(input int x, input int y, input int c);
    int n;
    bus.plot   = 1'b1;
    bus.x      = 8'(x);
    bus.y      = 7'(y);
    bus.colour = c[0];
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("plot_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 25000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 19200);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    bus.plot = 0; bus.x = 0; bus.y = 0; bus.colour = 0;
    bus.rd_en = 0; bus.rd_x = 0; bus.rd_y = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_colour", int'(bus.rd_colour), 0);
    chk("rst_pixel_count", int'(pixel_count), 0);
    rst = 1'b0;
    wait_sweep("init_sweep_cycles");
    rd(0, 0, 0);
    rd(159, 119, 0);

    // 5x5 block of 1s at (10,20)
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        plot_px(10 + j, 20 + i, 1);
    bus.plot = 1'b0;
    idle(8);
    chk("block_pixel_count", int'(pixel_count), 25);
    rd(14, 24, 1);
    rd(15, 24, 0);
    rd(10, 20, 1);
    rd(9, 20, 0);

    // Clear with two entries held in the FIFO by readback
    bus.rd_en = 1; bus.rd_x = 0; bus.rd_y = 0; exp_q.push_back(0);
    bus.plot = 1; bus.x = 3; bus.y = 3; bus.colour = 1;
    @(negedge clk);
    chk("clr_ready_before", int'(bus.ready), 1);
    @(posedge clk); #1;
    exp_q.push_back(0);
    bus.x = 4; bus.y = 4;
    @(posedge clk); #1;
    bus.rd_en = 0; bus.plot = 0; clear = 1;
    @(negedge clk);
    chk("clr_ready_during_clear", int'(bus.ready), 0);
    @(posedge clk); #1;
    clear = 0;
    wait_sweep("clr_sweep_cycles");
    chk("clr_pixel_count", int'(pixel_count), 0);
    rd(3, 3, 0);
    rd(4, 4, 0);
    rd(14, 24, 0);

    // Readback held for 10 cycles stalls draining; FIFO fills at 4
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.rd_en = 1; bus.rd_x = 0; bus.rd_y = 0; exp_q.push_back(0);
      bus.plot = 1; bus.x = 8'(40 + acc); bus.y = 50; bus.colour = 1;
      @(negedge clk);
      if (bus.ready) acc++;
      @(posedge clk); #1;
    end
    bus.rd_en = 0; bus.plot = 0;
    chk("stall_accepted", acc, 4);
    chk("stall_ready_full", int'(bus.ready), 0);
    chk("stall_pixel_count", int'(pixel_count), 0);
    plot_px(44, 50, 1);
    plot_px(45, 50, 1);
    bus.plot = 0;
    idle(8);
    chk("stall_final_count", int'(pixel_count), 6);
    rd(40, 50, 1);
    rd(45, 50, 1);
    rd(46, 50, 0);

    // Out-of-range column
    plot_px(165, 5, 1);
    bus.plot = 0;
    idle(8);
`ifdef FB_CLIP_EN
    chk("oor_pixel_count", int'(pixel_count), 6);
    rd(5, 5, 0);
    rd(165, 5, 0);
`else
    chk("oor_pixel_count", int'(pixel_count), 7);
    rd(5, 5, 1);
    rd(165, 5, 1);
`endif

    // Reset with three entries queued behind readback
    for (int i = 0; i < 3; i++) begin
      bus.rd_en = 1; bus.rd_x = 0; bus.rd_y = 0; exp_q.push_back(0);
      bus.plot = 1; bus.x = 8'(7 + i); bus.y = 7'(7 + i); bus.colour = 1;
      @(posedge clk); #1;
    end
    bus.rd_en = 0; bus.plot = 0; rst = 1;
    @(posedge clk); #1;
    chk("midrst_ready", int'(bus.ready), 0);
    chk("midrst_pixel_count", int'(pixel_count), 0);
    chk("midrst_rd_valid", int'(bus.rd_valid), 0);
    @(posedge clk); #1;
    rst = 0;
    wait_sweep("midrst_sweep_cycles");
    chk("midrst_count_after", int'(pixel_count), 0);
    rd(7, 7, 0);
    rd(8, 8, 0);
    rd(9, 9, 0);
    rd(5, 5, 0);

    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
